// File: rtl/elevator_pkg.sv
// elevator_pkg: shared floor-count defaults and auxiliary channel offsets for the elevator input front end
package elevator_pkg;
  localparam int NUM_FLOORS = 8;
  localparam int NUM_AUX = 4;
  // Auxiliary channels sit above the 4*NUM_FLOORS per-floor channels
  localparam int CH_OPEN = 0;
  localparam int CH_CLOSE = 1;
  localparam int CH_OVERWEIGHT = 2;
  localparam int CH_FIRE = 3;
  function automatic int floor_w(input int nf);
    return nf > 1 ? $clog2(nf) : 1;
  endfunction
  localparam int FLOOR_W = floor_w(NUM_FLOORS);
endpackage

// File: rtl/input_debounce.sv
// input_debounce: synchroniser chain plus counter debouncer with a rising-edge flag for one channel
module input_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic level_d;
  logic s;
  assign s = sync[SYNC_STAGES-1];
  assign rise = level & ~level_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
      level_d <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      level_d <= level;
      if (s == level) cnt <= '0;
      else if (cnt == LAST) begin
        level <= s;
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/elevator_input_conditioner.sv
// elevator_input_conditioner: debounces all pins, latches hall/cab requests, pulses door buttons, encodes floor
module elevator_input_conditioner
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_FLOORS-1:0]           button_up,
  input  logic [NUM_FLOORS-1:0]           button_down,
  input  logic [NUM_FLOORS-1:0]           button_select_floor,
  input  logic                            button_open,
  input  logic                            button_close,
  input  logic [NUM_FLOORS-1:0]           floor_sensor,
  input  logic                            overweight_alert,
  input  logic                            fire_alert,
  input  logic [NUM_FLOORS-1:0]           clear_up,
  input  logic [NUM_FLOORS-1:0]           clear_down,
  input  logic [NUM_FLOORS-1:0]           clear_cab,
  output logic [NUM_FLOORS-1:0]           up_req,
  output logic [NUM_FLOORS-1:0]           down_req,
  output logic [NUM_FLOORS-1:0]           cab_req,
  output logic                            any_req,
  output logic                            open_pulse,
  output logic                            close_pulse,
  output logic [floor_w(NUM_FLOORS)-1:0]  floor_idx,
  output logic                            floor_valid,
  output logic                            floor_err,
  output logic                            overweight_ff,
  output logic                            fire_ff
);
  localparam int NF = NUM_FLOORS;
  localparam int FW = floor_w(NF);
  localparam int AUX = 4 * NF;
  localparam int NCH = AUX + NUM_AUX;
  localparam logic [NF-1:0] UP_MASK = {1'b0, {(NF-1){1'b1}}};
  localparam logic [NF-1:0] DN_MASK = {{(NF-1){1'b1}}, 1'b0};
  logic [NCH-1:0] raw, level, rise;
  logic [NF-1:0] sensor;
  logic [FW:0] pc;
  logic [FW-1:0] idx;
  logic fire_lvl;
  logic unused;
  assign raw = {fire_alert, overweight_alert, button_close, button_open,
                floor_sensor, button_select_floor, button_down, button_up};
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    input_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk(clk),
      .rst(rst),
      .din(raw[i]),
      .level(level[i]),
      .rise(rise[i])
    );
  end
  assign sensor = level[4*NF-1:3*NF];
  assign fire_lvl = level[AUX+CH_FIRE];
  assign any_req = |{up_req, down_req, cab_req};
  assign unused = ^{level[3*NF-1:0], level[AUX+CH_CLOSE:AUX+CH_OPEN],
                    rise[4*NF-1:3*NF], rise[AUX+CH_FIRE:AUX+CH_OVERWEIGHT]};
  always_comb begin
    pc = '0;
    idx = '0;
    for (int k = 0; k < NF; k++) begin
      if (sensor[k]) begin
        pc = pc + (FW+1)'(1);
        idx = FW'(k);
      end
    end
  end
  // Fire uses the debounced level so requests drop on the same edge fire_ff rises
  always_ff @(posedge clk) begin
    if (rst) begin
      up_req <= '0;
      down_req <= '0;
      cab_req <= '0;
      open_pulse <= 1'b0;
      close_pulse <= 1'b0;
      floor_idx <= '0;
      floor_valid <= 1'b0;
      floor_err <= 1'b0;
      overweight_ff <= 1'b0;
      fire_ff <= 1'b0;
    end else begin
      up_req <= fire_lvl ? '0 : (up_req | rise[NF-1:0]) & ~clear_up & UP_MASK;
      down_req <= fire_lvl ? '0 : (down_req | rise[2*NF-1:NF]) & ~clear_down & DN_MASK;
      cab_req <= fire_lvl ? '0 : (cab_req | rise[3*NF-1:2*NF]) & ~clear_cab;
      open_pulse <= rise[AUX+CH_OPEN];
      close_pulse <= rise[AUX+CH_CLOSE];
      floor_valid <= pc == 1;
      floor_err <= pc > 1;
      floor_idx <= pc == 1 ? idx : floor_idx;
      overweight_ff <= level[AUX+CH_OVERWEIGHT];
      fire_ff <= fire_lvl;
    end
  end
endmodule

// File: tb/tb_elevator_input_conditioner.sv
// tb_elevator_input_conditioner: scoreboard bench with a window-based behavioural model of the input front end
module tb_elevator_input_conditioner;
  localparam int NF = 8;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int AUX = 4 * NF;
  localparam int NCH = AUX + 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NF-1:0] button_up = '0, button_down = '0, button_select_floor = '0, floor_sensor = '0;
  logic [NF-1:0] clear_up = '0, clear_down = '0, clear_cab = '0;
  logic button_open = 1'b0, button_close = 1'b0, overweight_alert = 1'b0, fire_alert = 1'b0;
  logic [NF-1:0] up_req, down_req, cab_req;
  logic any_req, open_pulse, close_pulse, floor_valid, floor_err, overweight_ff, fire_ff;
  logic [2:0] floor_idx;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  elevator_input_conditioner #(.NUM_FLOORS(NF), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .button_up(button_up), .button_down(button_down),
    .button_select_floor(button_select_floor), .button_open(button_open), .button_close(button_close),
    .floor_sensor(floor_sensor), .overweight_alert(overweight_alert), .fire_alert(fire_alert),
    .clear_up(clear_up), .clear_down(clear_down), .clear_cab(clear_cab),
    .up_req(up_req), .down_req(down_req), .cab_req(cab_req), .any_req(any_req),
    .open_pulse(open_pulse), .close_pulse(close_pulse), .floor_idx(floor_idx),
    .floor_valid(floor_valid), .floor_err(floor_err), .overweight_ff(overweight_ff), .fire_ff(fire_ff)
  );
  typedef struct packed {
    logic [NF-1:0] up, dn, cab;
    logic any, op, cl;
    logic [2:0] idx;
    logic fv, fe, ow, fi;
  } out_t;
  out_t exp_q[$];
  // Model state: a pin delay line, a window of recent synced samples, and the abstract request sets
  logic [NCH-1:0] syn1 = '0, syn2 = '0, stab = '0, stab_p = '0;
  logic [DB-1:0] hist [NCH];
  logic [NF-1:0] m_up = '0, m_dn = '0, m_cab = '0;
  logic [2:0] m_idx = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Predicts the outputs after the next rising edge from the inputs now on the pins
  task automatic model_step();
    logic [NCH-1:0] pins, rise, nstab;
    out_t e;
    int pc;
    pins = {fire_alert, overweight_alert, button_close, button_open,
            floor_sensor, button_select_floor, button_down, button_up};
    rise = stab & ~stab_p;
    e = '0;
    if (rst) begin
      syn1 = '0; syn2 = '0; stab = '0; stab_p = '0;
      foreach (hist[c]) hist[c] = '0;
      m_up = '0; m_dn = '0; m_cab = '0; m_idx = '0;
    end else begin
      if (stab[AUX+3]) begin
        m_up = '0; m_dn = '0; m_cab = '0;
      end else begin
        m_up = (m_up | rise[NF-1:0]) & ~clear_up;
        m_dn = (m_dn | rise[2*NF-1:NF]) & ~clear_down;
        m_cab = (m_cab | rise[3*NF-1:2*NF]) & ~clear_cab;
        m_up[NF-1] = 1'b0;
        m_dn[0] = 1'b0;
      end
      pc = $countones(stab[4*NF-1:3*NF]);
      if (pc == 1) for (int k = 0; k < NF; k++) if (stab[3*NF+k]) m_idx = 3'(k);
      e.fv = pc == 1;
      e.fe = pc > 1;
      e.op = rise[AUX];
      e.cl = rise[AUX+1];
      e.ow = stab[AUX+2];
      e.fi = stab[AUX+3];
      for (int c = 0; c < NCH; c++) begin
        hist[c] = {hist[c][DB-2:0], syn2[c]};
        nstab[c] = (hist[c] == {DB{~stab[c]}}) ? ~stab[c] : stab[c];
      end
      stab_p = stab; stab = nstab; syn2 = syn1; syn1 = pins;
    end
    e.up = m_up; e.dn = m_dn; e.cab = m_cab; e.idx = m_idx;
    e.any = |{m_up, m_dn, m_cab};
    exp_q.push_back(e);
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("up_req", 32'(up_req), 32'(e.up));
        chk("down_req", 32'(down_req), 32'(e.dn));
        chk("cab_req", 32'(cab_req), 32'(e.cab));
        chk("any_req", 32'(any_req), 32'(e.any));
        chk("open_pulse", 32'(open_pulse), 32'(e.op));
        chk("close_pulse", 32'(close_pulse), 32'(e.cl));
        chk("floor_idx", 32'(floor_idx), 32'(e.idx));
        chk("floor_valid", 32'(floor_valid), 32'(e.fv));
        chk("floor_err", 32'(floor_err), 32'(e.fe));
        chk("overweight_ff", 32'(overweight_ff), 32'(e.ow));
        chk("fire_ff", 32'(fire_ff), 32'(e.fi));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w;
    foreach (hist[c]) hist[c] = '0;
    idle(3);
    rst = 1'b0;
    chk("reset_state", {up_req, down_req, cab_req, any_req, open_pulse, close_pulse, floor_idx,
                        floor_valid, floor_err, overweight_ff, fire_ff}, '0);
    button_select_floor = 8'h10;
    idle(6);
    chk("cab_latency_edge6", 32'(cab_req), 32'h00);
    step();
    chk("cab_latency_edge7", 32'(cab_req), 32'h10);
    idle(3);
    button_select_floor = '0;
    idle(10);
    chk("cab_sticky", 32'(cab_req), 32'h10);
    clear_cab = 8'h10;
    step();
    clear_cab = '0;
    chk("cab_cleared", 32'(cab_req), 32'h00);
    button_up = 8'h04;
    idle(3);
    button_up = '0;
    idle(10);
    chk("up_glitch_ignored", 32'(up_req), 32'h00);
    button_up = 8'h04;
    idle(4);
    button_up = '0;
    idle(10);
    chk("up_4cycle_latched", 32'(up_req), 32'h04);
    button_up = 8'h08;
    idle(6);
    clear_up = 8'h08;
    step();
    clear_up = '0;
    chk("clear_beats_rise", 32'(up_req), 32'h04);
    button_up = 8'h80;
    button_down = 8'h01;
    idle(10);
    button_up = '0;
    button_down = '0;
    idle(10);
    chk("top_up_tied", 32'(up_req), 32'h04);
    chk("bottom_down_tied", 32'(down_req), 32'h00);
    button_select_floor = 8'h5A;
    idle(8);
    button_select_floor = '0;
    idle(10);
    chk("cab_5a", 32'(cab_req), 32'h5A);
    fire_alert = 1'b1;
    idle(6);
    chk("fire_edge6_cab", 32'(cab_req), 32'h5A);
    step();
    chk("fire_edge7_cab", 32'(cab_req), 32'h00);
    chk("fire_edge7_ff", 32'(fire_ff), 32'h1);
    button_select_floor = 8'h01;
    idle(10);
    button_select_floor = '0;
    idle(5);
    chk("press_during_fire", 32'(cab_req), 32'h00);
    fire_alert = 1'b0;
    idle(10);
    chk("fire_released", 32'(fire_ff), 32'h0);
    button_select_floor = 8'h01;
    idle(10);
    button_select_floor = '0;
    idle(3);
    chk("press_after_fire", 32'(cab_req), 32'h01);
    clear_cab = '1;
    step();
    clear_cab = '0;
    floor_sensor = 8'h01;
    idle(10);
    chk("floor_01_idx", 32'(floor_idx), 32'd0);
    chk("floor_01_valid", 32'(floor_valid), 32'd1);
    floor_sensor = 8'h00;
    idle(10);
    chk("floor_00_valid", 32'(floor_valid), 32'd0);
    chk("floor_00_idx", 32'(floor_idx), 32'd0);
    floor_sensor = 8'h04;
    idle(10);
    chk("floor_04_idx", 32'(floor_idx), 32'd2);
    floor_sensor = 8'h0C;
    idle(10);
    chk("floor_0c_err", 32'(floor_err), 32'd1);
    chk("floor_0c_idx", 32'(floor_idx), 32'd2);
    floor_sensor = '0;
    button_open = 1'b1;
    n = 0;
    repeat (20) begin
      step();
      n += int'(open_pulse);
    end
    button_open = 1'b0;
    chk("open_pulse_count", 32'(n), 32'd1);
    idle(10);
    button_select_floor = 8'h08;
    idle(4);
    rst = 1'b1;
    button_select_floor = '0;
    step();
    rst = 1'b0;
    chk("mid_reset_outputs", {up_req, down_req, cab_req, any_req, open_pulse, close_pulse, floor_idx,
                              floor_valid, floor_err, overweight_ff, fire_ff}, '0);
    idle(10);
    chk("no_stale_request", 32'(cab_req), 32'h00);
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NF; k++) begin
        if ($urandom_range(15) == 0) button_up[k] = ~button_up[k];
        if ($urandom_range(15) == 0) button_down[k] = ~button_down[k];
        if ($urandom_range(15) == 0) button_select_floor[k] = ~button_select_floor[k];
        if ($urandom_range(39) == 0) floor_sensor[k] = ~floor_sensor[k];
        clear_up[k] = $urandom_range(31) == 0;
        clear_down[k] = $urandom_range(31) == 0;
        clear_cab[k] = $urandom_range(31) == 0;
      end
      if ($urandom_range(15) == 0) button_open = ~button_open;
      if ($urandom_range(15) == 0) button_close = ~button_close;
      if ($urandom_range(15) == 0) overweight_alert = ~overweight_alert;
      if ($urandom_range(99) == 0) fire_alert = ~fire_alert;
      rst = $urandom_range(499) == 0;
      step();
    end
    rst = 1'b0;
    {button_up, button_down, button_select_floor, floor_sensor} = '0;
    {clear_up, clear_down, clear_cab} = '0;
    {button_open, button_close, overweight_alert, fire_alert} = '0;
    idle(20);
    w = 0;
    while (exp_q.size() > 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
